path_sequencer: RTL and testbench

- Memory-mapped path buffer and dispatcher between the pipelined RISC-V CPU data bus and the robot motion controller.
- The CPU writes path node IDs one per store to NODE_ADR, then commits the path with a store to CTRL_ADR.
- The block then issues the nodes in order to the motion controller over a valid/ready handshake.
- It reports progress through a readable status word and a one-cycle completion pulse.

---
 rtl/path_sequencer.sv | 166 ++++++++++++++++
 tb/tb_path_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/path_sequencer.sv
// rtl/path_sequencer.sv - CPU-loaded path buffer dispatching node IDs over valid/ready
module path_sequencer #(
    parameter int          MAX_NODES  = 16,
    parameter int          NODE_W     = 5,
    parameter logic [31:0] NODE_ADR   = 32'h0200_0008,
    parameter logic [31:0] CTRL_ADR   = 32'h0200_000C,
    parameter logic [31:0] STATUS_ADR = 32'h0200_0010
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic [31:0]       DataAdr,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic [NODE_W-1:0] node_id,
    output logic              node_valid,
    input  logic              node_ready,
    output logic              node_last,
    output logic              busy,
    output logic              path_done,
    output logic              overflow
);

    localparam int PTR_W = $clog2(MAX_NODES);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    count_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic                overflow_q;
    logic                node_valid_q;
    logic                node_last_q;
    logic                busy_q;
    logic                path_done_q;
    logic [NODE_W-1:0]   node_id_q;
    logic [NODE_W-1:0]   buf_q [MAX_NODES];

    logic                node_wr;
    logic                ctrl_wr;
    logic                commit;
    logic                abort;
    logic                buf_full;
    logic                handshake;
    logic [PTR_W-1:0]    rd_ptr_inc;
    logic [CNT_W-1:0]    last_idx;
    logic [31:0]         status_word;

    assign node_wr    = MemWrite && (DataAdr == NODE_ADR);
    assign ctrl_wr    = MemWrite && (DataAdr == CTRL_ADR);
    // The full data word is compared so that e.g. 0x101 is not mistaken for a commit
    assign commit     = ctrl_wr && (WriteData == 32'd1);
    assign abort      = ctrl_wr && (WriteData == 32'd2);
    assign buf_full   = (count_q == CNT_W'(MAX_NODES));
    assign handshake  = node_valid_q && node_ready;
    assign rd_ptr_inc = rd_ptr_q + PTR_W'(1);
    assign last_idx   = count_q - CNT_W'(1);

    // Path storage: nodes are appended only while loading and not yet full
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && node_wr && !buf_full) begin
            buf_q[count_q[PTR_W-1:0]] <= WriteData[NODE_W-1:0];
        end
    end

    // Load/run/done sequencer with all dispatch outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_LOAD;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            node_valid_q <= 1'b0;
            node_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            path_done_q  <= 1'b0;
            node_id_q    <= '0;
        end else if (abort) begin
            // Abort wins over a handshake in the same cycle: no DONE, no pulse
            state_q      <= S_LOAD;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            node_valid_q <= 1'b0;
            node_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            path_done_q  <= 1'b0;
        end else begin
            path_done_q <= 1'b0;
            case (state_q)
                S_LOAD: begin
                    if (node_wr) begin
                        if (buf_full) begin
                            overflow_q <= 1'b1;
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end else if (commit) begin
                        rd_ptr_q <= '0;
                        if (count_q != '0) begin
                            state_q      <= S_RUN;
                            busy_q       <= 1'b1;
                            node_valid_q <= 1'b1;
                            node_id_q    <= buf_q[0];
                            node_last_q  <= (count_q == CNT_W'(1));
                        end else begin
                            state_q     <= S_DONE;
                            path_done_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (node_wr) begin
                        overflow_q <= 1'b1;
                    end
                    if (handshake) begin
                        if (node_last_q) begin
                            state_q      <= S_DONE;
                            busy_q       <= 1'b0;
                            node_valid_q <= 1'b0;
                            node_last_q  <= 1'b0;
                            path_done_q  <= 1'b1;
                        end else begin
                            // Preload the following node so accepts can go back to back
                            rd_ptr_q    <= rd_ptr_inc;
                            node_id_q   <= buf_q[rd_ptr_inc];
                            node_last_q <= ({1'b0, rd_ptr_inc} == last_idx);
                        end
                    end
                end
                S_DONE: begin
                    state_q  <= S_LOAD;
                    count_q  <= '0;
                    rd_ptr_q <= '0;
                end
                default: begin
                    state_q <= S_LOAD;
                end
            endcase
        end
    end

    // Status word, visible only when the status address is presented
    always_comb begin
        status_word        = '0;
        status_word[0]     = busy_q;
        status_word[1]     = overflow_q;
        status_word[2]     = (state_q == S_DONE);
        status_word[12:8]  = 5'(count_q);
        status_word[20:16] = 5'(rd_ptr_q);
        ReadData           = (DataAdr == STATUS_ADR) ? status_word : 32'd0;
    end

    assign node_id    = node_id_q;
    assign node_valid = node_valid_q;
    assign node_last  = node_last_q;
    assign busy       = busy_q;
    assign path_done  = path_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_path_sequencer.sv
// tb/tb_path_sequencer.sv - randomized self-checking bench for path_sequencer
module tb_path_sequencer;

    localparam logic [31:0] NODE_ADR   = 32'h0200_0008;
    localparam logic [31:0] CTRL_ADR   = 32'h0200_000C;
    localparam logic [31:0] STATUS_ADR = 32'h0200_0010;
    localparam int          DEPTH      = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [4:0]  node_id;
    logic        node_valid;
    logic        node_ready;
    logic        node_last;
    logic        busy;
    logic        path_done;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;
    bit ovf_m = 1'b0;
    int model_q[$];

    always #5 clk = ~clk;

    path_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .DataAdr    (DataAdr),
        .WriteData  (WriteData),
        .ReadData   (ReadData),
        .node_id    (node_id),
        .node_valid (node_valid),
        .node_ready (node_ready),
        .node_last  (node_last),
        .busy       (busy),
        .path_done  (path_done),
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        @(negedge clk);
        MemWrite  = 1'b0;
        DataAdr   = 32'h0;
        WriteData = 32'h0;
    endtask

    task automatic read_status(output logic [31:0] v);
        DataAdr = STATUS_ADR;
        #1;
        v = ReadData;
    endtask

    // Store a node with random upper data bits; model keeps the first DEPTH node IDs
    task automatic node_write(input int v);
        cpu_write(NODE_ADR, ($urandom() & 32'hFFFF_FFE0) | 32'(v & 31));
        if (model_q.size() < DEPTH) model_q.push_back(v & 31);
        else ovf_m = 1'b1;
    endtask

    task automatic junk_op();
        case ($urandom_range(0, 4))
            0: @(negedge clk);
            1: cpu_write(CTRL_ADR, 32'h0000_0101);
            2: cpu_write(CTRL_ADR, 32'h3);
            3: cpu_write(32'h0200_0004, $urandom());
            default: cpu_write(STATUS_ADR, 32'h1);
        endcase
    endtask

    task automatic check_load_status();
        logic [31:0] s;
        read_status(s);
        check("load_status", s, 32'((ovf_m ? 2 : 0) + (model_q.size() << 8)));
    endtask

    // mode 0: ready high; 1: random ready plus stray writes; 2: 4-cycle stall on second node
    task automatic dispatch(input int mode);
        int idx = 0;
        int len = model_q.size();
        int cyc = 0;
        int stall = 0;
        bit hs;
        bit inj;
        logic [31:0] s;
        cpu_write(CTRL_ADR, 32'h1);
        while (idx < len && cyc < 500) begin
            check("run_valid", node_valid, 1);
            check("run_id", node_id, model_q[idx]);
            check("run_last", node_last, idx == len - 1);
            check("run_busy", busy, 1);
            check("run_pdone", path_done, 0);
            read_status(s);
            check("run_status", s, 32'(1 + (ovf_m ? 2 : 0) + (len << 8) + (idx << 16)));
            case (mode)
                0: node_ready = 1'b1;
                1: node_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (idx == 1 && stall < 4) begin
                        node_ready = 1'b0;
                        stall++;
                    end else begin
                        node_ready = 1'b1;
                    end
                end
            endcase
            inj = 1'b0;
            if (mode == 1) begin
                case ($urandom_range(0, 7))
                    0: begin MemWrite = 1'b1; DataAdr = NODE_ADR; WriteData = $urandom(); inj = 1'b1; end
                    1: begin MemWrite = 1'b1; DataAdr = CTRL_ADR; WriteData = 32'h1; end
                    default: ;
                endcase
            end
            hs = node_valid && node_ready;
            @(negedge clk);
            MemWrite   = 1'b0;
            node_ready = 1'b0;
            if (inj) ovf_m = 1'b1;
            if (hs) idx++;
            cyc++;
        end
        check("run_timeout", 32'(cyc < 500), 1);
        check("done_pdone", path_done, 1);
        check("done_valid", node_valid, 0);
        check("done_busy", busy, 0);
        check("done_ovf", overflow, ovf_m);
        read_status(s);
        check("done_status", s[2:0], {1'b1, ovf_m, 1'b0});
        @(negedge clk);
        check("post_pdone", path_done, 0);
        check("post_valid", node_valid, 0);
        read_status(s);
        check("post_status", s, 32'(ovf_m ? 2 : 0));
        model_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] s;
        reset = 1'b1; MemWrite = 1'b0; DataAdr = 32'h0; WriteData = 32'h0; node_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_valid", node_valid, 0);
        check("rst_id", node_id, 0);
        check("rst_last", node_last, 0);
        check("rst_busy", busy, 0);
        check("rst_pdone", path_done, 0);
        check("rst_ovf", overflow, 0);
        read_status(s);
        check("rst_status", s, 0);

        // Basic dispatch, then backpressure on node 7
        node_write(3); node_write(7); node_write(12);
        check_load_status();
        dispatch(0);
        node_write(3); node_write(7); node_write(12);
        dispatch(2);

        // Overflow: 17 writes, 16 kept
        for (int i = 0; i <= 16; i++) node_write(i);
        check_load_status();
        check("ovf_port", overflow, 1);
        dispatch(0);

        // Empty commit keeps overflow sticky
        dispatch(0);

        // Abort after one handshake of a 4-node path
        for (int i = 0; i < 4; i++) node_write($urandom_range(0, 31));
        cpu_write(CTRL_ADR, 32'h1);
        check("abort_pre_valid", node_valid, 1);
        node_ready = 1'b1;
        @(negedge clk);
        node_ready = 1'b0;
        check("abort_pre_id", node_id, model_q[1]);
        cpu_write(CTRL_ADR, 32'h2);
        model_q.delete(); ovf_m = 1'b0;
        check("abort_valid", node_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_ovf", overflow, 0);
        read_status(s);
        check("abort_status", s, 0);
        for (int i = 0; i < 3; i++) begin
            check("abort_pdone", path_done, 0);
            @(negedge clk);
        end
        node_write(9); node_write(21);
        check_load_status();
        dispatch(0);

        // Abort coinciding with the last handshake suppresses completion
        node_write(17);
        cpu_write(CTRL_ADR, 32'h1);
        check("prio_valid", node_valid, 1);
        node_ready = 1'b1;
        cpu_write(CTRL_ADR, 32'h2);
        node_ready = 1'b0;
        model_q.delete();
        check("prio_pdone", path_done, 0);
        check("prio_valid_off", node_valid, 0);
        read_status(s);
        check("prio_status", s, 0);
        @(negedge clk);
        check("prio_pdone2", path_done, 0);

        // Reset while the second of five nodes is presented
        for (int i = 0; i < 5; i++) node_write($urandom_range(1, 31));
        cpu_write(CTRL_ADR, 32'h1);
        node_ready = 1'b1;
        @(negedge clk);
        check("rrun_id", node_id, model_q[1]);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; node_ready = 1'b0;
        model_q.delete(); ovf_m = 1'b0;
        check("rrun_valid", node_valid, 0);
        check("rrun_id0", node_id, 0);
        check("rrun_last", node_last, 0);
        check("rrun_busy", busy, 0);
        check("rrun_pdone", path_done, 0);
        check("rrun_ovf", overflow, 0);
        read_status(s);
        check("rrun_status", s, 0);
        dispatch(0);

        // Randomized paths with junk traffic and random ready patterns
        for (int r = 0; r < 12; r++) begin
            int n = $urandom_range(0, 20);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) junk_op();
                node_write($urandom_range(0, 31));
            end
            check_load_status();
            dispatch($urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
